prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Serial program loader, directly upstream of the 16x8 program RAM.
- Receives 8N1 UART bytes on a single input pin and writes them to consecutive RAM addresses 0..15.
- Drives the RAM programming port: prog_mode, prog_addr, w_data.
- Lets the 8-bit CPU be programmed in silicon without the DIP-switch programming path.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit period; must be at least 4 and even.
- DEPTH, 16, number of bytes per load; equals the RAM depth; prog_addr width is fixed at 4.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  UART serial data, idle high, asynchronous to clk.
- load_start  input  1  one-cycle pulse; arms a new 16-byte load.
- prog_mode  output  1  RAM write strobe; high exactly one cycle per accepted byte.
- prog_addr  output  4  RAM write address; valid while prog_mode is high.
- w_data  output  8  RAM write data; valid while prog_mode is high.
- busy  output  1  high from load_start until the 16th write completes.
- done  output  1  one-cycle pulse the cycle after the 16th write.
- frame_err  output  1  sticky; set on a bad stop bit, cleared by load_start.

Behaviour:
- Reset values (rst low, asynchronous):
  - All outputs 0.
  - State IDLE, address counter 0.
  - rx synchroniser flops preset to 1.
- rx synchronisation: rx passes through a 2-flop synchroniser; all sampling uses the synchronised value.
  - Edge to first sample is 2 cycles.
- States: IDLE, WAIT_START, START, DATA, STOP, WRITE.
- IDLE:
  - rx is ignored.
  - load_start moves to WAIT_START, clears the address counter to 0, clears frame_err and sets busy.
- WAIT_START: a synchronised rx of 0 moves to START and clears the bit timer.
- START:
  - The line is re-sampled at CLKS_PER_BIT/2 - 1.
  - If it is 0: go to DATA, reset the timer and clear the bit index.
  - If it is 1 (glitch): return to WAIT_START with no error.
- DATA:
  - One sample every CLKS_PER_BIT cycles, which falls at mid-bit.
  - Bits are shifted in LSB first.
  - After bit index 7, go to STOP.
- STOP, sampled after CLKS_PER_BIT cycles:
  - If 1: go to WRITE.
  - If 0: set frame_err, discard the byte, keep the address unchanged, and go to WAIT_START.
- WRITE (one cycle):
  - prog_mode = 1, prog_addr = counter, w_data = received byte.
  - The next cycle the counter increments.
  - If the counter was 15: go to IDLE, drop busy and pulse done (counter wraps to 0).
  - Otherwise go to WAIT_START.
- Output registration: prog_addr and w_data are registered and held stable outside WRITE; only prog_mode gates the RAM write.
- Minimum RAM-write to next-start spacing is half a bit period, which needs no handshake.
- load_start while busy is a restart: counter goes to 0, frame_err is cleared, state goes to WAIT_START, and any partial byte is dropped.
- load_start coinciding with WRITE: the write still occurs, then the restart takes effect.
- rx held low in IDLE: no effect.
- rx held low after arming is treated as a start bit. The resulting byte is 0x00 with a bad stop bit, so frame_err is set.
- Reset mid-byte: returns to IDLE immediately. Any prog_mode pulse in flight is cut; the partially loaded RAM is left as is.

Decomposition:
- Package prog_loader_pkg holds:
  - the state enum typedef (loader_state_t);
  - localparam ADDR_W = 4;
  - localparam DATA_W = 8.
- Sub-module uart_rx_core holds the synchroniser, bit timer and shift register. Its outputs are:
  - byte_valid pulse;
  - byte_data[7:0];
  - stop_err pulse.
- prog_loader then holds only the IDLE/WAIT/WRITE sequencing and the address counter.

Test Plan:
- Full load: run with CLKS_PER_BIT=4. Pulse load_start, send bytes 0x00..0x0F, one per 8N1 frame.
  - Required: 16 single-cycle prog_mode pulses with prog_addr = w_data = 0..15.
  - done pulses once after the last; busy falls the same cycle; frame_err stays 0.
- LSB-first check: send 0xA5 and 0x3C as the first two bytes.
  - Required: w_data = 0xA5 at addr 0 and 0x3C at addr 1.
- Framing error: send 0x55 with stop bit 0, then 0x77 valid.
  - Required: frame_err = 1, no prog_mode for 0x55, and 0x77 is written at addr 0.
- Glitch rejection: drive a 1-cycle low pulse on rx after arming.
  - Required: no DATA entry, no write, no error; the next valid byte lands at addr 0.
- Restart: after 5 bytes, pulse load_start, then send 16 bytes 0xF0..0xFF.
  - Required: writes restart at addr 0 with 0xF0, and done pulses after 0xFF.
- Reset mid-frame: assert rst low during data bit 3 of byte 2.
  - Required: all outputs 0 asynchronously, and no prog_mode until the next load_start. Bytes sent while idle produce no writes.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and widths for the serial program loader
package prog_loader_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        START,
        DATA,
        STOP,
        WRITE
    } loader_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 receiver: rx synchroniser, bit timer and LSB-first shift register
module uart_rx_core
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              restart,
    input  logic              enable,
    output logic              byte_valid,
    output logic [DATA_W-1:0] byte_data,
    output logic              stop_err
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

    loader_state_t     state;
    logic              rx_meta;
    logic              rx_sync;
    logic [TW-1:0]     timer;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shreg;

    assign byte_data = shreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            state      <= IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
            // A restart drops any partial byte and re-hunts for a start bit.
            if (restart) begin
                state <= WAIT_START;
            end else if (!enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    WAIT_START: begin
                        if (!rx_sync) begin
                            state <= START;
                            timer <= '0;
                        end
                    end
                    START: begin
                        if (timer == HALF_M1) begin
                            timer <= '0;
                            if (!rx_sync) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end else begin
                                state <= WAIT_START;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    DATA: begin
                        if (timer == FULL_M1) begin
                            timer <= '0;
                            shreg <= {rx_sync, shreg[DATA_W-1:1]};
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    STOP: begin
                        if (timer == FULL_M1) begin
                            timer <= '0;
                            state <= WAIT_START;
                            if (rx_sync) begin
                                byte_valid <= 1'b1;
                            end else begin
                                stop_err <= 1'b1;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads 16 UART bytes into consecutive program RAM addresses
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              load_start,
    output logic              prog_mode,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    loader_state_t     state;
    logic [ADDR_W-1:0] cnt;
    logic              byte_valid;
    logic [DATA_W-1:0] byte_data;
    logic              stop_err;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .restart   (load_start),
        .enable    (state != IDLE),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .stop_err  (stop_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            prog_mode <= 1'b0;
            prog_addr <= '0;
            w_data    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            prog_mode <= 1'b0;
            done      <= 1'b0;
            // prog_mode is already high during WRITE, so a restart there still lets that write land.
            if (load_start) begin
                state     <= WAIT_START;
                cnt       <= '0;
                frame_err <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    WAIT_START: begin
                        if (byte_valid) begin
                            state     <= WRITE;
                            prog_mode <= 1'b1;
                            prog_addr <= cnt;
                            w_data    <= byte_data;
                        end else if (stop_err) begin
                            frame_err <= 1'b1;
                        end
                    end
                    WRITE: begin
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= WAIT_START;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for the serial program loader
module tb_prog_loader;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       load_start = 1'b0;
    logic       prog_mode;
    logic [3:0] prog_addr;
    logic [7:0] w_data;
    logic       busy;
    logic       done;
    logic       frame_err;

    always #5 clk = ~clk;

    prog_loader #(
        .CLKS_PER_BIT(C),
        .DEPTH       (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .load_start(load_start),
        .prog_mode (prog_mode),
        .prog_addr (prog_addr),
        .w_data    (w_data),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err)
    );

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_wr = -100;
    int         done_cnt = 0;
    int         d0;
    logic [11:0] q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every RAM write must match the head of the expected queue.
    always @(negedge clk) begin
        logic [11:0] e;
        cyc++;
        if (prog_mode === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h want no write", prog_addr, w_data);
            end else begin
                e = q.pop_front();
                check("wr_addr", 32'(prog_addr), 32'(e[11:8]));
                check("wr_data", 32'(w_data), 32'(e[7:0]));
            end
            last_wr = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            check("done_after_last_write", 32'(cyc - last_wr), 32'd1);
            check("busy_low_at_done", 32'(busy), 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load_start = 1'b1;
        tick(1);
        load_start = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(C);
        end
        rx = stop_bit;
        tick(C);
        rx = 1'b1;
        tick(1);
    endtask

    task automatic expect_send(input logic [3:0] a, input logic [7:0] d);
        q.push_back({a, d});
        send_frame(d, 1'b1);
    endtask

    initial begin
        logic [7:0] b3;
        b3 = 8'h33;

        tick(3);
        check("reset_outputs", 32'({prog_mode, prog_addr, w_data, busy, done, frame_err}), 32'd0);
        rst = 1'b1;
        tick(2);
        check("idle_outputs", 32'({prog_mode, prog_addr, w_data, busy, done, frame_err}), 32'd0);

        // Full load 0x00..0x0F
        pulse_load();
        check("busy_after_load_start", 32'(busy), 32'd1);
        for (int i = 0; i < 16; i++) expect_send(4'(i), 8'(i));
        tick(6);
        check("full_done_count", 32'(done_cnt), 32'd1);
        check("full_busy_low", 32'(busy), 32'd0);
        check("full_frame_err", 32'(frame_err), 32'd0);
        check("full_queue_empty", 32'(q.size()), 32'd0);

        // LSB-first ordering
        pulse_load();
        expect_send(4'd0, 8'hA5);
        expect_send(4'd1, 8'h3C);
        tick(4);
        check("lsb_queue_empty", 32'(q.size()), 32'd0);
        check("lsb_still_busy", 32'(busy), 32'd1);

        // Framing error: 0x55 with a low stop bit is dropped
        pulse_load();
        send_frame(8'h55, 1'b0);
        tick(8);
        check("frame_err_set", 32'(frame_err), 32'd1);
        expect_send(4'd0, 8'h77);
        tick(4);
        check("frame_err_sticky", 32'(frame_err), 32'd1);
        check("frame_queue_empty", 32'(q.size()), 32'd0);

        // Glitch rejection
        pulse_load();
        check("frame_err_cleared", 32'(frame_err), 32'd0);
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(12);
        check("glitch_no_error", 32'(frame_err), 32'd0);
        expect_send(4'd0, 8'h42);
        tick(4);
        check("glitch_queue_empty", 32'(q.size()), 32'd0);
        check("glitch_no_error_after", 32'(frame_err), 32'd0);

        // Restart after 5 bytes
        d0 = done_cnt;
        pulse_load();
        for (int i = 0; i < 5; i++) expect_send(4'(i), 8'(i * 3 + 1));
        tick(4);
        pulse_load();
        for (int i = 0; i < 16; i++) expect_send(4'(i), 8'(8'hF0 + i));
        tick(6);
        check("restart_done_count", 32'(done_cnt - d0), 32'd1);
        check("restart_busy_low", 32'(busy), 32'd0);
        check("restart_queue_empty", 32'(q.size()), 32'd0);

        // Reset during data bit 3 of byte 2
        pulse_load();
        expect_send(4'd0, 8'h11);
        expect_send(4'd1, 8'h22);
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 3; i++) begin
            rx = b3[i];
            tick(C);
        end
        rx = b3[3];
        tick(2);
        rst = 1'b0;
        #1;
        check("async_reset_outputs", 32'({prog_mode, prog_addr, w_data, busy, done, frame_err}), 32'd0);
        tick(3);
        rx = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(2);
        d0 = done_cnt;
        send_frame(8'h5A, 1'b1);
        send_frame(8'h66, 1'b1);
        tick(6);
        check("idle_after_reset_busy", 32'(busy), 32'd0);
        check("idle_after_reset_no_done", 32'(done_cnt - d0), 32'd0);
        check("idle_after_reset_queue", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
